wr_port_arbiter: RTL and testbench
==================================

Name: wr_port_arbiter

Overview:
- Shares one 8-bit write channel of the connector fabric between N independent write requesters (default 3, matching the wen/i_data channel groups).
- Round-robin arbitration with a bounded burst per grant.
- One registered output stage carrying a source index and honouring downstream backpressure.
- A freeze input stalls new acceptances without corrupting the beat already in flight.

Parameters:
- N, 3: number of requesters (2..8).
- DW, 8: data width per beat.
- BURST, 4: maximum beats accepted per grant (1..16).
- SW, $clog2(N): width of the source index.

Ports:
- clk  in  1  single clock; all flops rise-edge.
- reset_n  in  1  asynchronous assert, active-low; deassertion synchronised externally.
- freeze  in  1  when 1, no new beats accepted and grants do not change.
- req_valid  in  N  per-requester beat valid.
- req_data  in  N*DW  per-requester data; slice i is [i*DW +: DW].
- req_ready  out  N  per-requester accept; at most one bit set.
- wr_en  out  1  output beat valid.
- wr_data  out  DW  output beat data.
- wr_src  out  SW  index of the requester that produced the beat.
- wr_ready  in  1  downstream accept of the output beat.
- busy  out  1  1 when state is GRANT or wr_en is 1.

Behaviour:
- Reset values: wr_en=0, wr_data=0, wr_src=0, req_ready=0, busy=0. Internal reset values: state=IDLE, gnt=0, last=N-1 (so requester 0 wins first), cnt=0.
- Transfer rules:
  - Requester transfer i: req_valid[i] & req_ready[i].
  - Output transfer: wr_en & wr_ready.
- out_free = !wr_en | wr_ready.
- req_ready[i] = (state==GRANT) & (gnt==i) & !freeze & out_free. It is purely combinational from registers plus freeze and wr_ready.
- IDLE:
  - If !freeze and any req_valid: gnt <= first set bit searching from last+1 modulo N; cnt <= 0; go to GRANT.
  - Otherwise stay in IDLE.
  - The grant cycle is a 1-cycle bubble.
- GRANT:
  - On a requester transfer: wr_data <= slice gnt, wr_src <= gnt, wr_en <= 1, cnt <= cnt+1.
  - If that transfer was beat number BURST (cnt==BURST-1): last <= gnt and go to IDLE.
  - If out_free & !freeze & !req_valid[gnt]: release without a transfer; last <= gnt and go to IDLE.
  - If freeze=1: hold state, gnt and cnt unchanged.
- Output register:
  - An output transfer with no same-cycle requester transfer clears wr_en.
  - An output transfer and a requester transfer in the same cycle reload the register; wr_en stays 1 and there is no bubble.
  - wr_data and wr_src hold while wr_en & !wr_ready.
- Latency: a requester beat accepted at edge k is visible on wr_en/wr_data after edge k.
- Throughput: BURST beats per grant plus 1 arbitration cycle.
- Freeze:
  - Does not block wr_ready draining; an in-flight beat still completes.
  - Asserted in IDLE: no grant is issued.
- Wrap-around: the search index wraps from N-1 to 0. cnt is $clog2(BURST+1) bits and never exceeds BURST-1 before release.
- Simultaneous events:
  - Release and a new request in the same cycle: the new grant is decided in the following IDLE cycle. No same-cycle regrant.
  - A requester dropping valid while it is not granted has no effect.
- Reset mid-operation: an in-flight beat is discarded (wr_en=0 immediately on reset assertion). Arbitration restarts with requester 0 first.
- Data on a requester is sampled only on its transfer cycle. req_data for non-granted requesters is ignored.

Decomposition:
- Shared package connector_pkg:
  - localparam DW_DEFAULT=8.
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e.
  - function rr_pick(req, last, n): returns the index of the first set bit after last, with wrap.
- Sub-module rr_select: combinational round-robin priority picker. Inputs req[N] and last[SW]; outputs pick[SW] and any.
- wr_port_arbiter instantiates rr_select once and holds the FSM, burst counter and output register.

Test Plan:
- Reset then req_valid=3'b111, data 0x10/0x20/0x30 constant, wr_ready=1, BURST=4 -> wr_src sequence 0,0,0,0,(bubble),1,1,1,1,(bubble),2,2,2,2 with matching data.
- Only requester 1 valid for 2 beats (0xA1, 0xA2) then drops -> two output beats src=1, grant released, busy=0 two cycles after the last beat drains.
- wr_ready=0 for 3 cycles while requester 0 streams 0x55,0x66 -> wr_data holds 0x55, req_ready=0, no beat lost; 0x66 follows on the cycle after wr_ready=1.
- freeze=1 mid-burst after 2 beats from requester 2 -> req_ready=0 and cnt held; the pending beat still drains. After freeze=0, exactly 2 more beats from requester 2, then requester 0 is granted.
- reset_n pulsed low while wr_en=1, src=1 -> wr_en=0 asynchronously. After release with all valid, first grant is requester 0.
- N=3, last=2, only requester 0 valid -> wrap-around pick gives gnt=0 and the first beat is src=0.

Source files
------------

// File: rtl/connector_pkg.sv
// Shared types and helpers for the connector-fabric write channel arbiters.
package connector_pkg;

   localparam int unsigned DW_DEFAULT = 8;
   localparam int unsigned MAX_N      = 8;
   localparam int unsigned MAX_SW     = 3;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

   // First set bit of req strictly after last, wrapping at n; 0 when req is empty.
   function automatic logic [MAX_SW-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                  input logic [MAX_SW-1:0] last,
                                                  input int unsigned n);
      logic [MAX_SW-1:0] pick;
      logic              found;
      int unsigned       idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_N; k++) begin
         idx = (32'(last) + k) % n;
         if (!found && (k <= n) && req[idx[MAX_SW-1:0]]) begin
            pick  = idx[MAX_SW-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/wr_port_arbiter_if.sv
// Requester-side beats and the shared output write channel of the arbiter.
interface wr_port_arbiter_if #(
   parameter int unsigned N  = 3,
   parameter int unsigned DW = connector_pkg::DW_DEFAULT,
   parameter int unsigned SW = $clog2(N)
);
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            wr_en;
   logic [DW-1:0]   wr_data;
   logic [SW-1:0]   wr_src;
   logic            wr_ready;

   modport master (input req_valid, req_data, wr_ready,
                   output req_ready, wr_en, wr_data, wr_src);
   modport slave  (output req_valid, req_data, wr_ready,
                   input req_ready, wr_en, wr_data, wr_src);
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester after the last winner.
module rr_select
   import connector_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] last,
   output logic [SW-1:0] pick,
   output logic          any
);

   always_comb begin
      pick = SW'(rr_pick(MAX_N'(req), MAX_SW'(last), N));
      any  = |req;
   end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin arbiter sharing one write channel between N requesters,
// bounded bursts per grant, single registered output stage with backpressure.
module wr_port_arbiter
   import connector_pkg::*;
#(
   parameter int unsigned N     = 3,
   parameter int unsigned DW    = DW_DEFAULT,
   parameter int unsigned BURST = 4,
   parameter int unsigned SW    = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               freeze,
   wr_port_arbiter_if.master  bus,
   output logic               busy
);

   localparam int unsigned    CW        = $clog2(BURST + 1);
   localparam logic [CW-1:0]  LAST_BEAT = CW'(BURST - 1);

   arb_state_e     state, state_nxt;
   logic [SW-1:0]  gnt, gnt_nxt;
   logic [SW-1:0]  last, last_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           wr_en_q, wr_en_nxt;
   logic [DW-1:0]  wr_data_q, wr_data_nxt;
   logic [SW-1:0]  wr_src_q, wr_src_nxt;

   logic [SW-1:0]  pick;
   logic           any;
   logic           sel_valid;
   logic [DW-1:0]  sel_data;
   logic           out_free;
   logic           open;
   logic           xfer;
   logic [N-1:0]   ready_c;

   rr_select #(.N(N), .SW(SW)) u_rr_select (
      .req  (bus.req_valid),
      .last (last),
      .pick (pick),
      .any  (any)
   );

   // Granted requester's beat and the accept window.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt == SW'(i)) begin
            sel_valid = bus.req_valid[i];
            sel_data  = bus.req_data[i*DW +: DW];
         end
      end
      out_free = !wr_en_q || bus.wr_ready;
      open     = (state == ARB_GRANT) && !freeze && out_free;
      xfer     = open && sel_valid;
      for (int unsigned i = 0; i < N; i++) begin
         ready_c[i] = open && (gnt == SW'(i));
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      last_nxt    = last;
      cnt_nxt     = cnt;
      wr_en_nxt   = wr_en_q && !bus.wr_ready;
      wr_data_nxt = wr_data_q;
      wr_src_nxt  = wr_src_q;

      if (xfer) begin
         wr_en_nxt   = 1'b1;
         wr_data_nxt = sel_data;
         wr_src_nxt  = gnt;
      end

      unique case (state)
         ARB_IDLE: begin
            if (!freeze && any) begin
               gnt_nxt   = pick;
               cnt_nxt   = '0;
               state_nxt = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (xfer) begin
               cnt_nxt = cnt + CW'(1);
               if (cnt == LAST_BEAT) begin
                  last_nxt  = gnt;
                  state_nxt = ARB_IDLE;
               end
            end else if (open) begin
               // Granted requester went quiet: give the channel back.
               last_nxt  = gnt;
               state_nxt = ARB_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ARB_IDLE;
         gnt       <= '0;
         last      <= SW'(N - 1);
         cnt       <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         wr_src_q  <= '0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         last      <= last_nxt;
         cnt       <= cnt_nxt;
         wr_en_q   <= wr_en_nxt;
         wr_data_q <= wr_data_nxt;
         wr_src_q  <= wr_src_nxt;
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.wr_src    = wr_src_q;
   assign busy          = (state == ARB_GRANT) || wr_en_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Scoreboard bench for wr_port_arbiter: expected beats queued at stimulus time,
// checked on every output transfer, plus cycle-level checks of timing and control.
module tb_wr_port_arbiter;

   typedef struct packed {
      logic [1:0] src;
      logic [7:0] data;
   } beat_t;

   logic clk;
   logic reset_n;
   logic freeze;
   logic busy;

   int vectors     = 0;
   int miscompares = 0;
   beat_t sb[$];

   wr_port_arbiter_if #(.N(3), .DW(8)) bus ();

   wr_port_arbiter #(.N(3), .DW(8), .BURST(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .freeze  (freeze),
      .bus     (bus.master),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int src, input logic [7:0] d);
      beat_t b;
      b.src  = 2'(src);
      b.data = d;
      sb.push_back(b);
   endtask

   // Every output transfer must match the oldest expected beat.
   always @(negedge clk) begin
      if (reset_n && bus.wr_en && bus.wr_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_beat", 32'(bus.wr_src), 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = sb.pop_front();
            check("sb_src", 32'(bus.wr_src), 32'(e.src));
            check("sb_data", 32'(bus.wr_data), 32'(e.data));
         end
      end
   end

   task automatic do_reset();
      reset_n       = 1'b0;
      freeze        = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.wr_ready  = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", 32'(bus.wr_en), 32'd0);
      check("rst_wr_data", 32'(bus.wr_data), 32'd0);
      check("rst_wr_src", 32'(bus.wr_src), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
   endtask

   task automatic send_beat(input int i, input logic [7:0] d);
      bit got;
      got = 1'b0;
      bus.req_valid[i] = 1'b1;
      bus.req_data[i*8 +: 8] = d;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.req_ready[i]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("hs_timeout", 32'd0, 32'd1);
      tick();
   endtask

   // All three requesters valid with constant data: 4-beat bursts, one bubble between.
   task automatic run_all(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
      for (int k = 0; k < 4; k++) push(0, d0);
      for (int k = 0; k < 4; k++) push(1, d1);
      for (int k = 0; k < 4; k++) push(2, d2);
      bus.req_data  = {d2, d1, d0};
      bus.req_valid = 3'b111;
      bus.wr_ready  = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("rr_wr_en", 32'(bus.wr_en), ((i % 5) != 1) ? 32'd1 : 32'd0);
      end
      bus.req_valid = '0;
      tick();
      tick();
      check("rr_drain", 32'(sb.size()), 32'd0);
      check("rr_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      // Round-robin bursts, then wrap from last=2 with only requester 0 valid.
      do_reset();
      run_all(8'h10, 8'h20, 8'h30);
      push(0, 8'h77);
      bus.req_data[7:0] = 8'h77;
      bus.req_valid     = 3'b001;
      tick();
      tick();
      check("wrap_wr_en", 32'(bus.wr_en), 32'd1);
      check("wrap_src", 32'(bus.wr_src), 32'd0);
      check("wrap_data", 32'(bus.wr_data), 32'h77);
      bus.req_valid = '0;
      tick();
      tick();
      check("wrap_drain", 32'(sb.size()), 32'd0);

      // Requester 1 sends two beats then drops valid: early release.
      do_reset();
      bus.wr_ready = 1'b1;
      push(1, 8'hA1);
      push(1, 8'hA2);
      send_beat(1, 8'hA1);
      send_beat(1, 8'hA2);
      bus.req_valid = '0;
      check("rel_wr_en", 32'(bus.wr_en), 32'd1);
      check("rel_src", 32'(bus.wr_src), 32'd1);
      check("rel_busy_hold", 32'(busy), 32'd1);
      tick();
      check("rel_busy_0", 32'(busy), 32'd0);
      tick();
      check("rel_busy_1", 32'(busy), 32'd0);
      check("rel_drain", 32'(sb.size()), 32'd0);

      // Backpressure: 0x55 held for 3 cycles, 0x66 loads back-to-back on release.
      do_reset();
      push(0, 8'h55);
      push(0, 8'h66);
      bus.wr_ready      = 1'b1;
      bus.req_data[7:0] = 8'h55;
      bus.req_valid     = 3'b001;
      tick();
      tick();
      check("bp_first", 32'(bus.wr_data), 32'h55);
      bus.wr_ready      = 1'b0;
      bus.req_data[7:0] = 8'h66;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_req_ready", 32'(bus.req_ready), 32'd0);
         check("bp_hold_data", 32'(bus.wr_data), 32'h55);
         check("bp_hold_en", 32'(bus.wr_en), 32'd1);
         tick();
      end
      bus.wr_ready = 1'b1;
      @(negedge clk);
      check("bp_resume_ready", 32'(bus.req_ready), 32'd1);
      tick();
      check("bp_second_en", 32'(bus.wr_en), 32'd1);
      check("bp_second", 32'(bus.wr_data), 32'h66);
      bus.req_valid = '0;
      tick();
      tick();
      check("bp_drain", 32'(sb.size()), 32'd0);

      // Freeze mid-burst on requester 2; burst limit then hands over to requester 0.
      do_reset();
      bus.wr_ready        = 1'b1;
      bus.req_data[23:16] = 8'hC0;
      bus.req_valid       = 3'b100;
      push(2, 8'hC0);
      push(2, 8'hC1);
      push(2, 8'hC2);
      push(2, 8'hC3);
      push(0, 8'h0A);
      tick();
      bus.req_valid[0]  = 1'b1;
      bus.req_data[7:0] = 8'h0A;
      tick();
      bus.req_data[23:16] = 8'hC1;
      tick();
      freeze              = 1'b1;
      bus.req_data[23:16] = 8'hC2;
      @(negedge clk);
      check("frz_ready_a", 32'(bus.req_ready), 32'd0);
      tick();
      check("frz_drained", 32'(bus.wr_en), 32'd0);
      @(negedge clk);
      check("frz_ready_b", 32'(bus.req_ready), 32'd0);
      check("frz_busy", 32'(busy), 32'd1);
      tick();
      check("frz_no_beat", 32'(bus.wr_en), 32'd0);
      freeze = 1'b0;
      tick();
      check("frz_c2", 32'(bus.wr_data), 32'hC2);
      bus.req_data[23:16] = 8'hC3;
      tick();
      check("frz_c3", 32'(bus.wr_data), 32'hC3);
      bus.req_data[23:16] = 8'hC4;
      tick();
      check("frz_bubble", 32'(bus.wr_en), 32'd0);
      tick();
      check("frz_next_src", 32'(bus.wr_src), 32'd0);
      check("frz_next_data", 32'(bus.wr_data), 32'h0A);
      bus.req_valid = '0;
      tick();
      tick();
      check("frz_drain", 32'(sb.size()), 32'd0);

      // Reset while a beat from requester 1 is stalled on the output.
      do_reset();
      push(1, 8'hB1);
      bus.req_data[15:8] = 8'hB1;
      bus.req_valid      = 3'b010;
      tick();
      tick();
      check("mid_wr_en", 32'(bus.wr_en), 32'd1);
      check("mid_src", 32'(bus.wr_src), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_async_clr", 32'(bus.wr_en), 32'd0);
      check("mid_async_busy", 32'(busy), 32'd0);
      do_reset();
      run_all(8'h50, 8'h51, 8'h52);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
